lmfe_feeder: RTL and testbench

Host-side streaming front end for the local median filter engine. Fetches a raw IMG_W×IMG_H 8-bit image from a synchronous source ROM and drives it into the engine's Din/in_en port, obeying the engine's busy back-pressure. Captures every filtered pixel from Dout/out_valid and writes it, in raster order, into a result RAM. Asserts done when the full frame has been returned. Sits between system memories and the filter engine; it is the initiator end of the engine's pixel-stream protocol.

---
 rtl/lmfe_feeder.sv | 156 +++++++++++++++
 tb/tb_lmfe_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmfe_feeder.sv
// lmfe_feeder: streams a raw frame from a source ROM into the local median
// filter engine (Din/in_en with busy back-pressure) and writes the filtered
// pixels returned on Dout/out_valid into a result RAM in raster order.
// Optional feature macro: LMFE_FEEDER_STALL_EN builds the back-pressure
// stall counter; when undefined stall_cnt is tied to zero.
module lmfe_feeder #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          rom_rd,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_q,
  output logic [7:0]    Din,
  output logic          in_en,
  input  logic          busy,
  input  logic [7:0]    Dout,
  input  logic          out_valid,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wd,
  output logic          done,
  output logic          err,
  output logic [15:0]   stall_cnt
);

  localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state;
  logic [AW:0] rd_cnt;
  logic [AW:0] tx_cnt;
  logic [AW:0] rx_cnt;
  logic [7:0]  fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        rd_pend;
  logic        run;
  logic        fifo_ne;
  logic        enter;
  logic [2:0]  occ;

  assign rom_addr = rd_cnt[AW-1:0];
  assign Din      = fifo_mem[rd_ptr];

  // Handshake decode. The prefetch budget counts the slot freed by a pop in
  // the same cycle; without that the 2-entry FIFO cannot sustain one pixel
  // per cycle against the one-cycle ROM latency.
  always_comb begin
    run     = (state == S_RUN);
    fifo_ne = (fifo_cnt != 2'd0);
    enter   = (state == S_IDLE) && start;
    in_en   = run && fifo_ne && !busy;
    occ     = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, in_en};
    rom_rd  = run && (rd_cnt < NPIX) && (occ < 3'd2);
  end

  // Frame sequencer; done is a registered one-cycle pulse while in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (tx_cnt == NPIX) state <= S_DRAIN;
        S_DRAIN: if (rx_cnt == NPIX) begin
                   state <= S_DONE;
                   done  <= 1'b1;
                 end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ROM read / engine transfer counters and the 2-entry prefetch FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt      <= '0;
      tx_cnt      <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= 8'd0;
      fifo_mem[1] <= 8'd0;
    end else if (enter) begin
      rd_cnt   <= '0;
      tx_cnt   <= '0;
      rd_pend  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rd_pend <= rom_rd;
      if (rom_rd) rd_cnt <= rd_cnt + ONE;
      if (rd_pend) begin
        fifo_mem[wr_ptr] <= rom_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (in_en) begin
        rd_ptr <= ~rd_ptr;
        tx_cnt <= tx_cnt + ONE;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, in_en};
    end
  end

  // Result capture into RAM, plus the sticky error for unexpected results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      ram_wd   <= 8'd0;
      err      <= 1'b0;
    end else begin
      ram_wr <= 1'b0;
      if (out_valid) begin
        if ((state == S_RUN || state == S_DRAIN) && rx_cnt < NPIX) begin
          ram_wr   <= 1'b1;
          ram_wd   <= Dout;
          ram_addr <= rx_cnt[AW-1:0];
          rx_cnt   <= rx_cnt + ONE;
        end else begin
          err <= 1'b1;
        end
      end
      if (enter) rx_cnt <= '0;
    end
  end

`ifdef LMFE_FEEDER_STALL_EN
  // Saturating count of RUN cycles where a pixel is ready but the engine is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (enter) begin
      stall_cnt <= 16'd0;
    end else if (run && fifo_ne && busy && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lmfe_feeder.sv
// Directed testbench for lmfe_feeder: ROM model returns addr[7:0], the engine
// is modelled as a one-cycle loopback of each transferred pixel.
module tb_lmfe_feeder;

  localparam int AW = 14;
  localparam int N  = 16384;
`ifdef LMFE_FEEDER_STALL_EN
  localparam logic [15:0] STALL_EXP = 16'd40;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy = 1'b0;
  logic          out_valid = 1'b0;
  logic [7:0]    rom_q = 8'd0;
  logic [7:0]    Dout = 8'd0;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [7:0]    Din;
  logic          in_en;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wd;
  logic          done;
  logic          err;
  logic [15:0]   stall_cnt;

  int errors = 0;
  int checks = 0;

  logic       pv = 1'b0;
  logic [7:0] pd = 8'd0;
  logic [7:0] rq = 8'd0;

  always #5 clk = ~clk;

  lmfe_feeder #(.IMG_W(128), .IMG_H(128), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
    .Din(Din), .in_en(in_en), .busy(busy),
    .Dout(Dout), .out_valid(out_valid),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .done(done), .err(err), .stall_cnt(stall_cnt)
  );

  // One clock cycle: drive inputs at the falling edge, settle, then record
  // what the ROM and engine models must return in the following cycle.
  task automatic step(input logic b, input logic s);
    @(negedge clk);
    busy = b;
    start = s;
    out_valid = pv;
    Dout = pd;
    rom_q = rq;
    #1;
    pv = in_en;
    pd = Din;
    if (rom_rd) rq = rom_addr[7:0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0; busy = 1'b0; out_valid = 1'b0; Dout = 8'd0; rom_q = 8'd0;
    pv = 1'b0; pd = 8'd0; rq = 8'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rom_rd, in_en, ram_wr, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {rom_rd, in_en, ram_wr, done, err});
    end
    checks++;
    if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    checks++;
    if (Din !== 8'd0) begin errors++; $display("FAIL reset_din: got %0d want 0", Din); end
    checks++;
    if (ram_addr !== '0 || ram_wd !== 8'd0) begin
      errors++; $display("FAIL reset_ram: got addr=%0d wd=%0d want 0/0", ram_addr, ram_wd);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0);
    checks++;
    if ({rom_rd, in_en, done} !== 3'b0) begin
      errors++; $display("FAIL idle_quiet: got %b want 000", {rom_rd, in_en, done});
    end
  endtask

  // Full frame with busy=0 (or busy 3 of every 8 cycles when stall_mode=1).
  task automatic test_frame(input logic stall_mode, input string tag);
    int cyc, tx, rx, bad_tx, bad_hold, bad_en, bad_rx, dones;
    int first_rd, first_en, last_addr, done_at, last_wr_at;
    logic b, prev_ov;
    cyc = 0; tx = 0; rx = 0; bad_tx = 0; bad_hold = 0; bad_en = 0; bad_rx = 0; dones = 0;
    first_rd = -1; first_en = -1; last_addr = -1; done_at = -1; last_wr_at = -2;
    prev_ov = 1'b0;
    step(1'b0, 1'b1);
    while (dones == 0 && cyc < 30000) begin
      cyc++;
      b = stall_mode && ((cyc % 8) >= 5);
      step(b, stall_mode && cyc == 1000);
      if (rom_rd && first_rd < 0) first_rd = cyc;
      if (rom_rd) last_addr = int'(rom_addr);
      if (stall_mode) begin
        if (cyc >= 3 && tx < N && in_en !== ~b) bad_en++;
        if (b && tx > 0 && tx < N && Din !== 8'(tx)) bad_hold++;
      end else begin
        if (in_en && cyc != tx + 3) bad_en++;
      end
      if (in_en) begin
        if (first_en < 0) first_en = cyc;
        if (Din !== 8'(tx)) bad_tx++;
        tx++;
      end
      if (ram_wr !== prev_ov) bad_rx++;
      if (ram_wr === 1'b1) begin
        if (ram_addr !== AW'(rx) || ram_wd !== 8'(rx)) bad_rx++;
        rx++;
        last_wr_at = cyc;
      end
      if (done === 1'b1) begin dones++; done_at = cyc; end
      prev_ov = out_valid;
    end
    repeat (3) begin
      step(1'b0, 1'b0);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (first_rd != 1) begin errors++; $display("FAIL %s first_rom_rd: got cycle %0d want 1", tag, first_rd); end
    checks++;
    if (first_en != 3) begin errors++; $display("FAIL %s first_in_en: got cycle %0d want 3", tag, first_en); end
    checks++;
    if (tx != N || bad_tx != 0) begin
      errors++; $display("FAIL %s din_seq: got %0d pixels %0d bad want %0d/0", tag, tx, bad_tx, N);
    end
    checks++;
    if (bad_en != 0) begin errors++; $display("FAIL %s in_en_timing: got %0d bad cycles want 0", tag, bad_en); end
    checks++;
    if (last_addr != N - 1) begin errors++; $display("FAIL %s last_rom_addr: got %0d want %0d", tag, last_addr, N - 1); end
    checks++;
    if (rx != N || bad_rx != 0) begin
      errors++; $display("FAIL %s ram_writes: got %0d writes %0d bad want %0d/0", tag, rx, bad_rx, N);
    end
    checks++;
    if (done_at != last_wr_at + 1) begin
      errors++; $display("FAIL %s done_timing: got cycle %0d want %0d", tag, done_at, last_wr_at + 1);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL %s done_pulses: got %0d want 1", tag, dones); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL %s err: got %b want 0", tag, err); end
    if (stall_mode) begin
      checks++;
      if (bad_hold != 0) begin errors++; $display("FAIL %s din_hold: got %0d bad cycles want 0", tag, bad_hold); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, tx;
    cyc = 0; tx = 0;
    step(1'b0, 1'b1);
    while (tx < 100 && cyc < 1000) begin
      step(1'b0, 1'b0);
      cyc++;
      if (in_en) tx++;
    end
    step(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if ({rom_rd, in_en, ram_wr, done, err} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: got %b want 00000", {rom_rd, in_en, ram_wr, done, err});
    end
    checks++;
    if (rom_addr !== '0 || Din !== 8'd0 || ram_addr !== '0 || ram_wd !== 8'd0) begin
      errors++; $display("FAIL mid_reset_data: got rom_addr=%0d Din=%0d ram_addr=%0d ram_wd=%0d want 0", rom_addr, Din, ram_addr, ram_wd);
    end
    pv = 1'b0; pd = 8'd0; rq = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (rom_rd !== 1'b1 || rom_addr !== '0) begin
      errors++; $display("FAIL restart_rd: got rd=%b addr=%0d want 1/0", rom_rd, rom_addr);
    end
    step(1'b0, 1'b0);
    checks++;
    if (in_en !== 1'b0) begin errors++; $display("FAIL restart_early: got in_en=%b want 0", in_en); end
    step(1'b0, 1'b0);
    checks++;
    if (in_en !== 1'b1 || Din !== 8'd0) begin
      errors++; $display("FAIL restart_first_din: got en=%b Din=%0d want 1/0", in_en, Din);
    end
    apply_reset();
  endtask

  task automatic test_err();
    @(negedge clk);
    out_valid = 1'b1; Dout = 8'hA5; start = 1'b0; busy = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (ram_wr !== 1'b0) begin errors++; $display("FAIL idle_out_valid_wr: got %b want 0", ram_wr); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL idle_out_valid_err: got %b want 1", err); end
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || in_en !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got err=%b in_en=%b want 1/1", err, in_en);
    end
    apply_reset();
    step(1'b0, 1'b0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b want 0", err); end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    step(1'b1, 1'b1);
    for (int c = 1; c <= 42; c++) begin
      step(1'b1, 1'b0);
      if (in_en !== 1'b0) bad++;
      if (c >= 3 && Din !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    step(1'b0, 1'b0);
    checks++;
    if (stall_cnt !== STALL_EXP) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, STALL_EXP); end
    checks++;
    if (in_en !== 1'b1 || Din !== 8'd0) begin
      errors++; $display("FAIL stall_release: got en=%b Din=%0d want 1/0", in_en, Din);
    end
    step(1'b0, 1'b0);
    checks++;
    if (in_en !== 1'b1 || Din !== 8'd1 || stall_cnt !== STALL_EXP) begin
      errors++; $display("FAIL stall_next: got en=%b Din=%0d stall=%0d want 1/1/%0d", in_en, Din, stall_cnt, STALL_EXP);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, "stream");
    test_frame(1'b1, "busy");
    test_reset_mid();
    test_err();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
